// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS/OVERSAMPLE at build time, parity and stop bits at runtime.
// Define UART_RX_BREAK_DET_EN to add the break_det output.
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 soft_rst,
  input  logic                 rx_en,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy,
  output logic                 baud_en
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   cfg_par_q, cfg_par_d;
  logic                   cfg_odd_q, cfg_odd_d;
  logic                   cfg_two_q, cfg_two_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                   par_bit_q, par_bit_d;
  logic                   brk_q, brk_d;
`endif

  logic rx_s, rx_fall, at_mid, at_end;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign at_mid  = baud_tick && (tick_q == TICK_MID);
  assign at_end  = baud_tick && (tick_q == TICK_END);

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    rx_prev_d  = rx_s;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    perr_acc_d = perr_acc_q;
    cfg_par_d  = cfg_par_q;
    cfg_odd_d  = cfg_odd_q;
    cfg_two_d  = cfg_two_q;
`ifdef UART_RX_BREAK_DET_EN
    par_bit_d  = par_bit_q;
    brk_d      = 1'b0;
`endif

    if (state_q != StIdle && baud_tick) tick_d = tick_q + 1'b1;

    case (state_q)
      StIdle: begin
        // A tick coinciding with the start edge is deliberately not counted.
        if (rx_fall && rx_en) begin
          state_d    = StStart;
          tick_d     = '0;
          bit_d      = '0;
          perr_acc_d = 1'b0;
          cfg_par_d  = parity_en;
          cfg_odd_d  = parity_odd;
          cfg_two_d  = two_stop;
`ifdef UART_RX_BREAK_DET_EN
          par_bit_d  = 1'b0;
`endif
        end
      end
      StStart: begin
        if (at_mid) begin
          tick_d  = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (at_end) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = cfg_par_q ? StParity : StStop1;
        end
      end
      StParity: begin
        if (at_end) begin
          tick_d     = '0;
          perr_acc_d = (^shift_q) ^ rx_s ^ cfg_odd_q;
          state_d    = StStop1;
`ifdef UART_RX_BREAK_DET_EN
          par_bit_d  = rx_s;
`endif
        end
      end
      StStop1: begin
        if (at_end) begin
          tick_d = '0;
          if (rx_s && cfg_two_q) begin
            state_d = StStop2;
          end else begin
            state_d = StIdle;
            valid_d = 1'b1;
            dout_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_BREAK_DET_EN
            brk_d   = ~rx_s && (shift_q == '0) && !par_bit_q;
`endif
          end
        end
      end
      StStop2: begin
        if (at_end) begin
          tick_d  = '0;
          state_d = StIdle;
          valid_d = 1'b1;
          dout_d  = shift_q;
          perr_d  = perr_acc_q;
          ferr_d  = ~rx_s;
        end
      end
      default: state_d = StIdle;
    endcase

    if (soft_rst) begin
      state_d    = StIdle;
      sync_d     = '1;
      rx_prev_d  = 1'b1;
      tick_d     = '0;
      bit_d      = '0;
      shift_d    = '0;
      dout_d     = '0;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      perr_acc_d = 1'b0;
      cfg_par_d  = 1'b0;
      cfg_odd_d  = 1'b0;
      cfg_two_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_d  = 1'b0;
      brk_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= StIdle;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      perr_acc_q <= 1'b0;
      cfg_par_q  <= 1'b0;
      cfg_odd_q  <= 1'b0;
      cfg_two_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      perr_acc_q <= perr_acc_d;
      cfg_par_q  <= cfg_par_d;
      cfg_odd_q  <= cfg_odd_d;
      cfg_two_q  <= cfg_two_d;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      par_bit_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      brk_q     <= brk_d;
    end
  end

  assign break_det = brk_q;
`endif

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != StIdle);
  assign baud_en    = busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed scoreboard bench for uart_rx_cfg: an 8-bit instance and a 7-bit instance for break frames.
module tb_uart_rx_cfg;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  logic soft_rst = 1'b0;
  logic rx_en = 1'b1;
  logic baud_tick = 1'b0;
  logic rx8 = 1'b1;
  logic rx7 = 1'b1;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic two_stop = 1'b0;
  logic [1:0] div = 2'd0;

  logic [7:0] dout8;
  logic [6:0] dout7;
  logic valid8, ferr8, perr8, busy8, ben8;
  logic valid7, ferr7, perr7, busy7, ben7;
`ifdef UART_RX_BREAK_DET_EN
  logic brk8, brk7;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int busy_ticks = 0;
  exp_t q8[$];
  exp_t q7[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .areset_n(areset_n), .soft_rst(soft_rst), .rx_en(rx_en), .baud_tick(baud_tick),
    .rx(rx8), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .data_out(dout8), .data_valid(valid8), .frame_err(ferr8), .parity_err(perr8),
    .busy(busy8), .baud_en(ben8)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk8)
`endif
  );

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut7 (
    .clk(clk), .areset_n(areset_n), .soft_rst(soft_rst), .rx_en(rx_en), .baud_tick(baud_tick),
    .rx(rx7), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .data_out(dout7), .data_valid(valid7), .frame_err(ferr7), .parity_err(perr7),
    .busy(busy7), .baud_en(ben7)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk7)
`endif
  );

  // Tick generator; also counts ticks seen while dut8 is busy.
  always @(negedge clk) begin
    baud_tick = (div == 2'd3);
    div = div + 2'd1;
    if (baud_tick && busy8) busy_ticks++;
  end

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid8) begin
      check("valid8_expected", 9'(q8.size() != 0), 9'd1);
      if (q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        check("data8", {1'b0, dout8}, e.data);
        check("ferr8", {8'd0, ferr8}, {8'd0, e.ferr});
        check("perr8", {8'd0, perr8}, {8'd0, e.perr});
        check("baud_en8", {8'd0, ben8}, {8'd0, busy8});
`ifdef UART_RX_BREAK_DET_EN
        check("brk8", {8'd0, brk8}, {8'd0, e.brk});
`endif
      end
    end
    if (valid7) begin
      check("valid7_expected", 9'(q7.size() != 0), 9'd1);
      if (q7.size() != 0) begin
        exp_t e;
        e = q7.pop_front();
        check("data7", {2'b0, dout7}, e.data);
        check("ferr7", {8'd0, ferr7}, {8'd0, e.ferr});
        check("perr7", {8'd0, perr7}, {8'd0, e.perr});
`ifdef UART_RX_BREAK_DET_EN
        check("brk7", {8'd0, brk7}, {8'd0, e.brk});
`endif
      end
    end
  end

  task automatic drive(input bit sel, input logic v, input int n);
    @(negedge clk);
    if (sel) rx7 = v;
    else rx8 = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input int nb, input logic [8:0] data, input bit pe,
                            input logic pbit, input logic s1, input bit two, input logic s2);
    drive(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < nb; i++) drive(sel, data[i], BIT_CLK);
    if (pe) drive(sel, pbit, BIT_CLK);
    drive(sel, s1, BIT_CLK);
    if (two) drive(sel, s2, BIT_CLK);
    drive(sel, 1'b1, BIT_CLK);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (q8.size() + q7.size()) != 0; i++) @(negedge clk);
    check(tag, 9'(q8.size() + q7.size()), 9'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {8'd0, busy8}, 9'd0);
    check("reset_data", {1'b0, dout8}, 9'd0);
    check("reset_valid", {8'd0, valid8}, 9'd0);

    // 8N1 0xA5 and busy duration
    busy_ticks = 0;
    q8.push_back('{data: 9'h0A5, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_a5");
    check("busy_ticks", 9'(busy_ticks), 9'd152);

    // even parity, correct then wrong parity bit
    parity_en = 1'b1;
    parity_odd = 1'b0;
    q8.push_back('{data: 9'h007, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_par_ok");
    q8.push_back('{data: 9'h007, ferr: 1'b0, perr: 1'b1, brk: 1'b0});
    send_frame(1'b0, 8, 9'h007, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_par_bad");

    // odd parity, 0x07 with parity bit 0 is correct
    parity_odd = 1'b1;
    q8.push_back('{data: 9'h007, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h007, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_par_odd");

    // two stop bits: second stop 0, then both stops 1
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b1;
    q8.push_back('{data: 9'h03C, ferr: 1'b1, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_stop2_bad");
    q8.push_back('{data: 9'h03C, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_stop2_ok");
    two_stop = 1'b0;

    // false start: 4-tick low pulse
    drive(1'b0, 1'b0, 16);
    check("false_start_busy", {8'd0, busy8}, 9'd1);
    drive(1'b0, 1'b1, 40);
    check("false_start_idle", {8'd0, busy8}, 9'd0);
    drive(1'b0, 1'b1, BIT_CLK * 12);

    // soft reset during data bit 3
    drive(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, BIT_CLK);
    drive(1'b0, 1'b0, BIT_CLK / 2);
    @(negedge clk);
    rx8 = 1'b1;
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    check("soft_rst_busy", {8'd0, busy8}, 9'd0);
    check("soft_rst_data", {1'b0, dout8}, 9'd0);
    drive(1'b0, 1'b1, BIT_CLK * 12);
    q8.push_back('{data: 9'h055, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h055, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_after_soft");

    // asynchronous reset during data bit 3
    drive(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, BIT_CLK);
    drive(1'b0, 1'b1, BIT_CLK / 2);
    #2 areset_n = 1'b0;
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    check("areset_busy", {8'd0, busy8}, 9'd0);
    check("areset_data", {1'b0, dout8}, 9'd0);
    drive(1'b0, 1'b1, BIT_CLK * 12);
    q8.push_back('{data: 9'h055, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b0, 8, 9'h055, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_after_areset");

    // break on the 7-bit instance: line low for 12 bit times
    q7.push_back('{data: 9'h000, ferr: 1'b1, perr: 1'b0, brk: 1'b1});
    drive(1'b1, 1'b0, BIT_CLK * 12);
    wait_drain("drain_break");
    check("break_hold_busy", {8'd0, busy7}, 9'd0);
    drive(1'b1, 1'b1, BIT_CLK * 2);
    check("break_release_busy", {8'd0, busy7}, 9'd0);
    q7.push_back('{data: 9'h055, ferr: 1'b0, perr: 1'b0, brk: 1'b0});
    send_frame(1'b1, 7, 9'h055, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_7bit");

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
